// File: rtl/uart_stim_tx.sv
// Purpose : byte-to-serial UART transmitter (8N1/8N2, LSB first) feeding a SoC UART rx pin,
//           with a DEPTH-entry FIFO in front of the serialiser.
// Latency : a byte pushed into an empty idle block at edge N drives the start bit from edge N+1.
// Backpr. : o_ready = !full (registered full only); a refused byte must be held with i_valid.
// Ports   : clk/rst        single clock, synchronous active-high reset
//           i_data/i_valid byte push port, accepted when i_valid && o_ready
//           o_ready        FIFO not full
//           o_tx           serial line, idle high
//           o_busy         frame on the line or FIFO non-empty
//           o_level        FIFO occupancy 0..DEPTH
module uart_stim_tx #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD        = 115200,
    parameter int DEPTH       = 16,
    parameter int STOP_BITS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int AW           = $clog2(DEPTH);
    localparam int PW           = AW + 1;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    // One counter serves both bit periods and the (possibly double) stop period.
    localparam int CW           = $clog2(STOP_CLKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);

    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_err
        $error("uart_stim_tx: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]      mem_q [DEPTH];

    logic            full, empty, push, pop;
    logic [7:0]      head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = i_valid && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign o_ready = !full;
    assign o_tx    = tx_q;
    assign o_busy  = (state_q != S_IDLE) || !empty;
    assign o_level = wr_ptr_q - rd_ptr_q;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Next bit is taken from the pre-shift value so it appears on this edge.
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_cnt_q == STOP_LAST) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule
